// File: rtl/dma_addr_gen_pkg.sv
// Shared definitions for the DMA address generator: instruction codes,
// control-register layout, counting modes and run-state encoding.
package dma_addr_gen_pkg;

  localparam logic [2:0] I_WRCR   = 3'b000;
  localparam logic [2:0] I_RDCR   = 3'b001;
  localparam logic [2:0] I_RDWC   = 3'b010;
  localparam logic [2:0] I_RDAC   = 3'b011;
  localparam logic [2:0] I_REINIT = 3'b100;
  localparam logic [2:0] I_LDAR   = 3'b101;
  localparam logic [2:0] I_LDWC   = 3'b110;
  localparam logic [2:0] I_START  = 3'b111;

  localparam int CR_MODE_LSB = 0;
  localparam int CR_MODE_MSB = 1;
  localparam int CR_DIR      = 2;
  localparam int CR_AUTO     = 3;

  typedef enum logic [1:0] {
    M_CNTDN    = 2'd0,
    M_CNTUP    = 2'd1,
    M_ADDRSTOP = 2'd2,
    M_INFINITE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dma_counter.sv
// Loadable up/down counter with a registered one-cycle wrap pulse.
// q_step exposes the post-step value so the parent can test terminal conditions.
module dma_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         down,
  output logic [W-1:0] q,
  output logic [W-1:0] q_step,
  output logic         wrap
);

  logic wrap_cond;

  assign q_step    = down ? (q - W'(1)) : (q + W'(1));
  assign wrap_cond = down ? (q == '0) : (q == '1);

  // A load wins over the step value, but a step that wrapped is still reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en & wrap_cond;
      if (load)
        q <= load_val;
      else if (en)
        q <= q_step;
    end
  end

endmodule

// File: rtl/dma_addr_gen.sv
// Parametrised Am2940-style DMA address generator with run/done sequencing,
// per-transfer handshake, selectable direction and chained-block auto-reload.
module dma_addr_gen
  import dma_addr_gen_pkg::*;
#(
  parameter int AW = 16,
  parameter int WW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    instr,
  input  logic          instr_vld,
  input  logic [AW-1:0] data_in,
  output logic [AW-1:0] data_out,
  output logic          oe_data,
  input  logic          xfer_req,
  output logic          xfer_ack,
  output logic [AW-1:0] addr,
  output logic          done,
  output logic          busy,
  output logic          aco,
  output logic          wco
);

  if (WW > AW) begin : g_bad_width
    $error("dma_addr_gen: WW must not exceed AW");
  end

  logic [3:0]    cr_reg, cr_next;
  logic [AW-1:0] ar_reg, ar_next;
  logic [WW-1:0] wcr_reg, wcr_next;
  state_e        state_reg, state_next;
  logic          done_reg, done_next;

  logic [AW-1:0] ac, ac_step, ac_load_val;
  logic [WW-1:0] wc, wc_step, wc_load_val;
  logic          ac_load, wc_load;
  mode_e         mode;
  logic          dir, autoreload, ctl_instr, term, step_term;

  assign mode       = mode_e'(cr_reg[CR_MODE_MSB:CR_MODE_LSB]);
  assign dir        = cr_reg[CR_DIR];
  assign autoreload = cr_reg[CR_AUTO];

  // Register-loading instructions pre-empt a same-cycle transfer.
  assign ctl_instr = instr_vld &&
                     (instr == I_REINIT || instr == I_LDAR || instr == I_LDWC);
  assign busy      = (state_reg == RUN);
  assign xfer_ack  = busy & xfer_req & ~ctl_instr;
  assign addr      = ac;
  assign done      = done_reg;

  dma_counter #(.W(AW)) u_ac (
    .clk      (clk),
    .rst      (reset),
    .load     (ac_load),
    .load_val (ac_load_val),
    .en       (xfer_ack),
    .down     (dir),
    .q        (ac),
    .q_step   (ac_step),
    .wrap     (aco)
  );

  // Word counter counts down in modes 0 and 2, up in modes 1 and 3.
  dma_counter #(.W(WW)) u_wc (
    .clk      (clk),
    .rst      (reset),
    .load     (wc_load),
    .load_val (wc_load_val),
    .en       (xfer_ack),
    .down     (~mode[0]),
    .q        (wc),
    .q_step   (wc_step),
    .wrap     (wco)
  );

  always_comb begin
    term = 1'b0;
    case (mode)
      M_CNTDN:    term = (wc_step == '0);
      M_CNTUP:    term = (wc_step == wcr_reg);
      M_ADDRSTOP: term = (ac_step == AW'(wcr_reg));
      default:    term = 1'b0;
    endcase
  end

  assign step_term = xfer_ack & term;

  always_comb begin
    state_next  = state_reg;
    done_next   = (state_reg == RUN) ? 1'b0 : done_reg;
    cr_next     = cr_reg;
    ar_next     = ar_reg;
    wcr_next    = wcr_reg;
    ac_load     = 1'b0;
    ac_load_val = ar_reg;
    wc_load     = 1'b0;
    wc_load_val = mode[0] ? '0 : wcr_reg;

    if (step_term) begin
      done_next = 1'b1;
      if (autoreload) begin
        ac_load = 1'b1;
        wc_load = 1'b1;
      end else begin
        state_next = DONE;
      end
    end

    if (instr_vld) begin
      case (instr)
        I_WRCR: cr_next = data_in[3:0];
        I_REINIT: begin
          ac_load    = 1'b1;
          wc_load    = 1'b1;
          state_next = IDLE;
          done_next  = 1'b0;
        end
        I_LDAR: begin
          ar_next     = data_in;
          ac_load     = 1'b1;
          ac_load_val = data_in;
          state_next  = IDLE;
          done_next   = 1'b0;
        end
        I_LDWC: begin
          wcr_next    = data_in[WW-1:0];
          wc_load     = 1'b1;
          wc_load_val = mode[0] ? '0 : data_in[WW-1:0];
          state_next  = IDLE;
          done_next   = 1'b0;
        end
        I_START: begin
          if (state_reg != RUN) begin
            if (mode == M_CNTDN && wc == '0) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
              done_next  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
      cr_reg    <= '0;
      ar_reg    <= '0;
      wcr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      cr_reg    <= cr_next;
      ar_reg    <= ar_next;
      wcr_reg   <= wcr_next;
    end
  end

  always_comb begin
    data_out = '0;
    oe_data  = 1'b0;
    if (instr_vld) begin
      case (instr)
        I_RDCR: begin oe_data = 1'b1; data_out = AW'(cr_reg); end
        I_RDWC: begin oe_data = 1'b1; data_out = AW'(wc);     end
        I_RDAC: begin oe_data = 1'b1; data_out = ac;          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_addr_gen.sv
// Self-checking bench for dma_addr_gen: expected transfer addresses are queued
// by the stimulus and consumed by a monitor whenever the DUT acknowledges.
module tb_dma_addr_gen;
  import dma_addr_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  instr = 3'b000;
  logic        instr_vld = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        oe_data;
  logic        xfer_req = 1'b0;
  logic        xfer_ack;
  logic [15:0] addr;
  logic        done, busy, aco, wco;

  logic [15:0] sb_q[$];
  int n_pass = 0;
  int n_total = 0;

  dma_addr_gen #(.AW(16), .WW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .instr_vld (instr_vld),
    .data_in   (data_in),
    .data_out  (data_out),
    .oe_data   (oe_data),
    .xfer_req  (xfer_req),
    .xfer_ack  (xfer_ack),
    .addr      (addr),
    .done      (done),
    .busy      (busy),
    .aco       (aco),
    .wco       (wco)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: every ack must match the oldest queued address.
  always @(negedge clk) begin
    if (xfer_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("ack_not_expected", {31'd0, xfer_ack}, 32'd0);
      end else begin
        logic [15:0] exp_addr;
        exp_addr = sb_q.pop_front();
        $display("xfer ack addr=0x%04h expected=0x%04h", addr, exp_addr);
        check("ack_addr", {16'd0, addr}, {16'd0, exp_addr});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [2:0] code, input logic [15:0] val);
    instr     = code;
    data_in   = val;
    instr_vld = 1'b1;
    step();
    instr_vld = 1'b0;
  endtask

  task automatic rd(input logic [2:0] code, input logic [15:0] exp, input string name);
    instr     = code;
    instr_vld = 1'b1;
    @(negedge clk);
    $display("read %s data_out=0x%04h oe=%0b", name, data_out, oe_data);
    check({name, "_oe"}, {31'd0, oe_data}, 32'd1);
    check(name, {16'd0, data_out}, {16'd0, exp});
    step();
    instr_vld = 1'b0;
  endtask

  initial begin
    // Reset state, with a request present that must be ignored.
    xfer_req = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {16'd0, addr}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ack", {31'd0, xfer_ack}, 32'd0);
    check("rst_aco_wco", {30'd0, aco, wco}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    xfer_req = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Mode 0 count-down: three transfers then DONE.
    do_instr(I_LDAR, 16'h1000);
    do_instr(I_LDWC, 16'h0003);
    do_instr(I_WRCR, 16'h0000);
    do_instr(I_START, 16'h0000);
    sb_q.push_back(16'h1000);
    sb_q.push_back(16'h1001);
    sb_q.push_back(16'h1002);
    xfer_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    check("m0_done", {31'd0, done}, 32'd1);
    check("m0_busy", {31'd0, busy}, 32'd0);
    check("m0_4th_ack", {31'd0, xfer_ack}, 32'd0);
    step();
    xfer_req = 1'b0;
    check("m0_queue_empty", sb_q.size(), 32'd0);
    rd(I_RDAC, 16'h1003, "m0_rdac");
    rd(I_RDWC, 16'h0000, "m0_rdwc");

    // Decrementing wrap in infinite mode.
    do_instr(I_LDAR, 16'h0001);
    do_instr(I_WRCR, 16'h0007);
    do_instr(I_START, 16'h0000);
    sb_q.push_back(16'h0001);
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'hFFFF);
    xfer_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dec_aco", {31'd0, aco}, (i == 2) ? 32'd1 : 32'd0);
      check("dec_done", {31'd0, done}, 32'd0);
      step();
    end
    xfer_req = 1'b0;
    @(negedge clk);
    check("dec_aco_after", {31'd0, aco}, 32'd0);
    check("dec_busy", {31'd0, busy}, 32'd1);
    step();
    check("dec_queue_empty", sb_q.size(), 32'd0);

    // Mode 2 with auto-reload: alternating addresses, done pulses.
    do_instr(I_LDAR, 16'h00F0);
    do_instr(I_LDWC, 16'h00F2);
    do_instr(I_WRCR, 16'h000A);
    do_instr(I_START, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(16'h00F0);
      sb_q.push_back(16'h00F1);
    end
    xfer_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ar_done", {31'd0, done}, (i == 2 || i == 4) ? 32'd1 : 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd1);
      step();
    end
    xfer_req = 1'b0;
    @(negedge clk);
    check("ar_done_last", {31'd0, done}, 32'd1);
    step();
    @(negedge clk);
    check("ar_done_clear", {31'd0, done}, 32'd0);
    check("ar_busy_end", {31'd0, busy}, 32'd1);
    step();
    check("ar_queue_empty", sb_q.size(), 32'd0);
    rd(I_RDCR, 16'h000A, "ar_rdcr");

    // Mode 0 START with zero word count goes straight to DONE.
    do_instr(I_LDWC, 16'h0000);
    do_instr(I_WRCR, 16'h0000);
    xfer_req = 1'b1;
    do_instr(I_START, 16'h0000);
    @(negedge clk);
    check("z_done", {31'd0, done}, 32'd1);
    check("z_busy", {31'd0, busy}, 32'd0);
    check("z_ack", {31'd0, xfer_ack}, 32'd0);
    step();
    @(negedge clk);
    check("z_ack2", {31'd0, xfer_ack}, 32'd0);
    step();
    xfer_req = 1'b0;

    // Collision: LDAR beats a same-cycle transfer request.
    do_instr(I_LDWC, 16'h0005);
    do_instr(I_START, 16'h0000);
    xfer_req  = 1'b1;
    instr     = I_LDAR;
    data_in   = 16'h2000;
    instr_vld = 1'b1;
    @(negedge clk);
    check("col_ack", {31'd0, xfer_ack}, 32'd0);
    check("col_busy_before", {31'd0, busy}, 32'd1);
    step();
    instr_vld = 1'b0;
    xfer_req  = 1'b0;
    @(negedge clk);
    check("col_addr", {16'd0, addr}, 32'h0000_2000);
    check("col_busy", {31'd0, busy}, 32'd0);
    check("col_done", {31'd0, done}, 32'd0);
    step();

    // Asynchronous reset in the middle of a run.
    do_instr(I_START, 16'h0000);
    sb_q.push_back(16'h2000);
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", {16'd0, addr}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_oe", {31'd0, oe_data}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    rd(I_RDCR, 16'h0000, "post_rst_rdcr");
    rd(I_RDWC, 16'h0000, "post_rst_rdwc");
    rd(I_RDAC, 16'h0000, "post_rst_rdac");

    check("final_queue_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
